// File: rtl/alu_stage.sv
// alu_stage: eight-bit arithmetic/logic stage that drives Register A's alu_result input.
//
// A start request captures operands B and C and a 3-bit function code. The stage then waits
// SETTLE_CYCLES clocks to model relay propagation. After that it registers the result and the
// sign/carry/zero condition flags, and raises result_valid for exactly one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   b_in, c_in   operands B and C (N bits)
//   func         operation select, latched together with the operands
//   start        request to begin an operation
//   alu_result   registered result; holds until the next completed operation
//   result_valid one-cycle strobe, high while in DONE
//   busy         high while in SETTLE or DONE
//   sign, carry, zero  condition flags of the last result
module alu_stage #(
  parameter int unsigned N             = 8,
  parameter int unsigned SETTLE_CYCLES = 3   // legal range 1..15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] c_in,
  input  logic [2:0]   func,
  input  logic         start,
  output logic [N-1:0] alu_result,
  output logic         result_valid,
  output logic         busy,
  output logic         sign,
  output logic         carry,
  output logic         zero
);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] b_q, b_d, c_q, c_d;
  logic [2:0]   func_q, func_d;
  logic [N-1:0] res_q, res_d;
  logic         sign_q, sign_d, carry_q, carry_d, zero_q, zero_d;
  logic         valid_q, valid_d, busy_q, busy_d;

  // Combinational ALU over the latched operands
  logic [N:0]   sum;
  logic [N-1:0] alu_r;
  logic         alu_c;

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    unique case (func_q)
      3'b000: begin
        sum   = {1'b0, b_q} + {1'b0, c_q};
        alu_r = sum[N-1:0];
        alu_c = sum[N];
      end
      3'b001: begin
        sum   = {1'b0, b_q} + (N+1)'(1);
        alu_r = sum[N-1:0];
        alu_c = sum[N];
      end
      3'b010: alu_r = b_q & c_q;
      3'b011: alu_r = b_q | c_q;
      3'b100: alu_r = b_q ^ c_q;
      3'b101: alu_r = ~b_q;
      3'b110: alu_r = {b_q[N-2:0], b_q[N-1]};
      3'b111: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    c_d     = c_q;
    func_d  = func_q;
    res_d   = res_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          b_d     = b_in;
          c_d     = c_in;
          func_d  = func;
          cnt_d   = CntInit;
          state_d = StSettle;
        end
      end
      StSettle: begin
        // Inputs, including start, are deliberately ignored while settling
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_r;
          sign_d  = alu_r[N-1];
          carry_d = alu_c;
          zero_d  = (alu_r == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        // A held start runs operations back-to-back without passing through IDLE
        if (start) begin
          b_d     = b_in;
          c_d     = c_in;
          func_d  = func;
          cnt_d   = CntInit;
          state_d = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies decoded from the next state
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      func_q  <= '0;
      res_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      c_q     <= c_d;
      func_q  <= func_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign alu_result   = res_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign sign         = sign_q;
  assign carry        = carry_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: self-checking bench for alu_stage. It applies directed and random operations
// and compares them against an arithmetic reference model and the expected latency.
module tb_alu_stage;

  localparam int S = 3;

  logic       clk;
  logic       reset;
  logic [7:0] b_in, c_in;
  logic [2:0] func;
  logic       start;
  logic [7:0] alu_result;
  logic       result_valid, busy, sign, carry, zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_stage #(.N(8), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .b_in         (b_in),
    .c_in         (c_in),
    .func         (func),
    .start        (start),
    .alu_result   (alu_result),
    .result_valid (result_valid),
    .busy         (busy),
    .sign         (sign),
    .carry        (carry),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {carry, result}, computed with plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input int f, input int b, input int c);
    int r;
    int cy;
    cy = 0;
    case (f)
      0: begin r = (b + c) % 256; cy = (b + c) / 256; end
      1: begin r = (b + 1) % 256; cy = (b == 255) ? 1 : 0; end
      2: r = b & c;
      3: r = b | c;
      4: r = b ^ c;
      5: r = 255 - b;
      6: r = (b * 2) % 256 + b / 128;
      default: r = 0;
    endcase
    return 9'(cy * 256 + r);
  endfunction

  // One operation with start pulsed for a single cycle. With disturb set, b_in is changed
  // and start is pulsed again while the stage is settling.
  task automatic do_op(input logic [7:0] b, input logic [7:0] c, input logic [2:0] f,
                       input bit disturb);
    logic [8:0] m;
    int lat;
    m = ref_alu(int'(f), int'(b), int'(c));
    @(negedge clk);
    b_in = b; c_in = c; func = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    if (disturb) b_in = 8'h00;
    while (!result_valid && lat < 20) begin
      check_eq("busy_settle", busy, 1);
      @(negedge clk);
      lat++;
      start = (disturb && lat == 1) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check_eq("latency", lat, S);
    check_eq("result", alu_result, m[7:0]);
    check_eq("carry", carry, m[8]);
    check_eq("sign", sign, m[7]);
    check_eq("zero", zero, (m[7:0] == 8'h00));
    check_eq("busy_done", busy, 1);
    @(negedge clk);
    check_eq("valid_strobe", result_valid, 0);
    check_eq("busy_idle", busy, 0);
    check_eq("result_hold", alu_result, m[7:0]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; b_in = '0; c_in = '0; func = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_result", alu_result, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {sign, carry, zero}, 0);

    do_op(8'h5A, 8'h33, 3'b000, 0);  // 8D, sign
    do_op(8'hFF, 8'h01, 3'b000, 0);  // overflow
    do_op(8'hFF, 8'h00, 3'b001, 0);  // INC wrap
    do_op(8'h81, 8'h00, 3'b110, 0);  // rotate -> 03
    do_op(8'hF0, 8'h3C, 3'b100, 1);  // XOR, disturbed -> CC
    repeat (S + 2) begin
      @(negedge clk);
      check_eq("no_extra_valid", result_valid, 0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    b_in = 8'hAA; c_in = 8'h0F; func = 3'b010; start = 1'b1;
    for (int i = 0; i < 4 * (S + 1); i++) begin
      @(negedge clk);
      check_eq("b2b_valid", result_valid, ((i % (S + 1)) == S));
      check_eq("b2b_busy", busy, 1);
      if (i >= S) check_eq("b2b_result", alu_result, 8'h0A);
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("b2b_end_busy", busy, 0);
    check_eq("b2b_end_valid", result_valid, 0);

    // NOT, then a CLR abandoned by reset in its second settle cycle
    do_op(8'h0F, 8'h00, 3'b101, 0);
    check_eq("not_sign", sign, 1);
    @(negedge clk);
    func = 3'b111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_result", alu_result, 0);
    check_eq("mid_rst_flags", {sign, carry, zero}, 0);
    check_eq("mid_rst_valid", result_valid, 0);
    repeat (S + 3) begin
      @(negedge clk);
      check_eq("mid_rst_no_valid", result_valid, 0);
      check_eq("mid_rst_idle", busy, 0);
    end

    // Random operations
    for (int k = 0; k < 40; k++) begin
      do_op(8'($urandom_range(255)), 8'($urandom_range(255)), 3'($urandom_range(7)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Eight-bit arithmetic/logic stage feeding Register A's `alu_result` input.
- Captures operands B and C plus a 3-bit function code on a start request.
- Holds the computation for a programmable settle interval, modelling relay propagation.
- Then presents a stable result with a one-cycle valid strobe, and updates the sign/carry/zero condition register consumed by the sequencer.

Parameters:
- N, 8, datapath width in bits; must match Register A.
- SETTLE_CYCLES, 3, number of clock cycles spent in SETTLE before the result is valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- b_in  input  N  operand B from the register unit.
- c_in  input  N  operand C from the register unit.
- func  input  3  operation select; sampled together with the operands.
- start  input  1  request to begin an operation.
- alu_result  output  N  result bus to Register A; held stable between operations.
- result_valid  output  1  one-cycle strobe; the sequencer asserts ldA in this cycle.
- busy  output  1  high while an operation is in progress (SETTLE or DONE).
- sign  output  1  condition flag: MSB of the last result.
- carry  output  1  condition flag: carry out of the last ADD/INC.
- zero  output  1  condition flag: last result equal to zero.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; operand/function latches, alu_result, sign, carry, zero all 0.
  - result_valid=0, busy=0.
  - Reset has priority over every other input, including mid-SETTLE/DONE: the operation is abandoned and no flag update occurs.
- States: IDLE, SETTLE, DONE. The down-counter cnt is 4 bits wide.
- IDLE:
  - busy=0.
  - start=1 at an edge → latch b_in, c_in, func; cnt←SETTLE_CYCLES-1; go to SETTLE.
  - start=0 → stay in IDLE.
- SETTLE:
  - busy=1.
  - cnt≠0 → cnt←cnt-1.
  - cnt=0 → at this edge, register alu_result and all three flags from the latched operands; go to DONE.
  - start is ignored; operand/func changes on the inputs have no effect.
- DONE:
  - busy=1, result_valid=1, for exactly one cycle.
  - Next edge: start=1 → latch new operands and go to SETTLE (back-to-back); otherwise go to IDLE.
- Latency: with start sampled at edge E0, result_valid is high between edges E0+SETTLE_CYCLES and E0+SETTLE_CYCLES+1.
- alu_result and the flags change only on the DONE-entry edge (or reset); otherwise they hold their value indefinitely.
- Functions (result = R, computed at N bits):
  - 000 ADD: R=B+C mod 2^N; carry=bit N of the (N+1)-bit sum.
  - 001 INC: R=B+1; carry=1 iff B=all ones.
  - 010 AND: R=B&C; carry=0.
  - 011 OR: R=B|C; carry=0.
  - 100 XOR: R=B^C; carry=0.
  - 101 NOT: R=~B; carry=0.
  - 110 SHL: circular left rotate of B by one, R={B[N-2:0],B[N-1]}; carry=0.
  - 111 CLR: R=0; carry=0.
- Flags for all functions: sign=R[N-1]; zero=(R==0).
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset then ADD:
  - reset 2 cycles; b_in=8'h5A, c_in=8'h33, func=000, start for 1 cycle.
  - result_valid high exactly 3 edges later; alu_result=8'h8D, sign=1, carry=0, zero=0.
  - busy high for 4 cycles.
- ADD overflow: b_in=8'hFF, c_in=8'h01, func=000 → alu_result=8'h00, carry=1, zero=1, sign=0.
- INC and SHL:
  - b_in=8'hFF, func=001 → alu_result=8'h00, carry=1, zero=1.
  - Then b_in=8'h81, func=110 → alu_result=8'h03, carry=0, sign=0.
- Logic ops with operand change mid-SETTLE:
  - b_in=8'hF0, c_in=8'h3C, func=100 (XOR); change b_in to 8'h00 one cycle after start.
  - Result is still 8'hCC; a start pulse during SETTLE is ignored (one result_valid only).
- Back-to-back: hold start=1 continuously with func=010 (AND), b_in=8'hAA, c_in=8'h0F.
  - result_valid pulses every SETTLE_CYCLES+1 cycles; alu_result=8'h0A, and it never glitches between pulses.
- Reset mid-operation:
  - Complete a NOT of 8'h0F (alu_result=8'hF0, sign=1).
  - Start CLR, assert reset at the second SETTLE cycle.
  - Next cycle: state IDLE, alu_result=0, flags 0, busy=0, and no result_valid pulse follows.
